// File: rtl/bram_bank_enable_sequencer_pkg.sv
// Shared types and bank-group helper for the BRAM bank enable sequencer.
package bram_seq_pkg;

   localparam int unsigned MAX_BANKS  = 64;
   localparam logic        POOL_BIG   = 1'b0;
   localparam logic        POOL_SMALL = 1'b1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;
   typedef enum logic [1:0] {M_CONV, M_POOL, M_FC, M_RSVD} layer_mode_t;

   typedef struct packed {
      layer_mode_t mode;
      logic        src_pool;
      logic        dst_pool;
      logic        src_half;
      logic        dst_half;
   } layer_desc_t;

   // Contiguous run of 'units' banks inside one half; the last partial group
   // is pulled back so it overlaps its predecessor instead of spilling over.
   function automatic logic [MAX_BANKS-1:0] group_mask(
      input int unsigned idx,
      input int unsigned units,
      input int unsigned half,
      input int unsigned half_banks
   );
      int unsigned          base;
      logic [MAX_BANKS-1:0] m;
      base = idx * units;
      if (base > half_banks - units) base = half_banks - units;
      base = base + half * half_banks;
      m = '0;
      for (int unsigned b = 0; b < MAX_BANKS; b++) begin
         m[b] = (b >= base) && (b < base + units);
      end
      return m;
   endfunction

endpackage

// File: rtl/bram_bank_enable_sequencer_if.sv
// Control/status bundle between the layer controller and the bank enable sequencer.
interface bram_bank_enable_sequencer_if #(
   parameter int unsigned N_BIG   = 12,
   parameter int unsigned N_SMALL = 32,
   parameter int unsigned CNT_W   = 5
);
   logic               i_start;
   logic               i_abort;
   logic [1:0]         i_mode;
   logic               i_src_pool;
   logic               i_dst_pool;
   logic               i_src_half;
   logic               i_dst_half;
   logic [CNT_W-1:0]   i_n_filters;
   logic [CNT_W-1:0]   i_n_loops;
   logic               i_step;

   logic               o_busy;
   logic               o_done;
   logic [CNT_W-1:0]   o_filter_idx;
   logic [CNT_W-1:0]   o_loop_idx;
   logic [N_BIG-1:0]   o_big_ena;
   logic [N_BIG-1:0]   o_big_enb;
   logic [N_SMALL-1:0] o_small_ena;
   logic [N_SMALL-1:0] o_small_enb;
   logic               o_cfg_err;

   modport master (
      output i_start, i_abort, i_mode, i_src_pool, i_dst_pool, i_src_half,
             i_dst_half, i_n_filters, i_n_loops, i_step,
      input  o_busy, o_done, o_filter_idx, o_loop_idx, o_big_ena, o_big_enb,
             o_small_ena, o_small_enb, o_cfg_err
   );

   modport slave (
      input  i_start, i_abort, i_mode, i_src_pool, i_dst_pool, i_src_half,
             i_dst_half, i_n_filters, i_n_loops, i_step,
      output o_busy, o_done, o_filter_idx, o_loop_idx, o_big_ena, o_big_enb,
             o_small_ena, o_small_enb, o_cfg_err
   );
endinterface

// File: rtl/bram_bank_enable_sequencer_bank_group_decoder.sv
// Per-pool decoder: turns (mode, half, filter/loop index) into port-A/port-B enable masks.
module bank_group_decoder
   import bram_seq_pkg::*;
#(
   parameter int unsigned NBANK      = 12,
   parameter int unsigned SA_UNITS   = 4,
   parameter int unsigned POOL_UNITS = 4,
   parameter int unsigned CNT_W      = 5
) (
   input  logic             i_active,
   input  layer_mode_t      i_mode,
   input  logic             i_rd_sel,
   input  logic             i_wr_sel,
   input  logic             i_rd_half,
   input  logic             i_wr_half,
   input  logic [CNT_W-1:0] i_filter,
   input  logic [CNT_W-1:0] i_loop,
   output logic [NBANK-1:0] o_ena,
   output logic [NBANK-1:0] o_enb,
   output logic             o_wr_oob
);

   localparam int unsigned H = NBANK / 2;

   logic [MAX_BANKS-1:0] w_rd;
   logic [MAX_BANKS-1:0] w_wr;

   always_comb begin
      w_rd     = '0;
      w_wr     = '0;
      o_wr_oob = 1'b0;
      if (i_active) begin
         case (i_mode)
            M_CONV: begin
               if (i_rd_sel) w_rd = group_mask(32'(i_loop), SA_UNITS, 32'(i_rd_half), H);
               if (i_wr_sel) begin
                  if (32'(i_filter) < H) w_wr = group_mask(32'(i_filter), 1, 32'(i_wr_half), H);
                  else                   o_wr_oob = 1'b1;
               end
            end
            M_POOL: begin
               if (i_rd_sel) w_rd = group_mask(32'(i_loop), POOL_UNITS, 32'(i_rd_half), H);
               if (i_wr_sel) w_wr = group_mask(32'(i_loop), POOL_UNITS, 32'(i_wr_half), H);
            end
            M_FC: begin
               if (i_rd_sel) w_rd = group_mask(0, H, 32'(i_rd_half), H);
            end
            default: ;
         endcase
      end
      o_enb = w_rd[NBANK-1:0];
      o_ena = w_wr[NBANK-1:0];
   end

endmodule

// File: rtl/bram_bank_enable_sequencer.sv
// Per-layer BRAM port-enable sequencer (BIG/SMALL ping-pong pools) with start/step/done handshake.
// Optional BANK_CONFLICT_CHK_EN: flags and masks same-bank port-A/port-B overlap while running.
module bram_bank_enable_sequencer
   import bram_seq_pkg::*;
#(
   parameter int unsigned N_BIG      = 12,
   parameter int unsigned N_SMALL    = 32,
   parameter int unsigned SA_UNITS   = 4,
   parameter int unsigned POOL_UNITS = 4,
   parameter int unsigned CNT_W      = 5
) (
   input logic                         clk,
   input logic                         rst_n,
   bram_bank_enable_sequencer_if.slave bus
);

   seq_state_t       r_state, w_state_nxt;
   layer_desc_t      r_desc, w_desc_nxt;
   logic [CNT_W-1:0] r_f_last, w_f_last_nxt;
   logic [CNT_W-1:0] r_l_last, w_l_last_nxt;
   logic [CNT_W-1:0] r_filter, w_filter_nxt;
   logic [CNT_W-1:0] r_loop, w_loop_nxt;
   logic             w_start_acc;
   logic             w_desc_err;

   logic             r_busy, r_done, r_cfg_err, w_cfg_err_nxt;
   logic [N_BIG-1:0]   r_big_ena, r_big_enb;
   logic [N_SMALL-1:0] r_small_ena, r_small_enb;

   logic [N_BIG-1:0]   w_big_ena_raw, w_big_enb, w_big_clash;
   logic [N_SMALL-1:0] w_small_ena_raw, w_small_enb, w_small_clash;
   logic               w_big_oob, w_small_oob;
   logic               w_active;

   // Next state, descriptor and counters; enables are decoded from these so
   // the registered enables always line up with the registered counters.
   always_comb begin
      w_state_nxt  = r_state;
      w_desc_nxt   = r_desc;
      w_f_last_nxt = r_f_last;
      w_l_last_nxt = r_l_last;
      w_filter_nxt = r_filter;
      w_loop_nxt   = r_loop;
      w_start_acc  = 1'b0;
      w_desc_err   = 1'b0;
      if (bus.i_abort) begin
         w_state_nxt  = IDLE;
         w_filter_nxt = '0;
         w_loop_nxt   = '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.i_start) begin
                  w_start_acc         = 1'b1;
                  w_desc_nxt.mode     = layer_mode_t'(bus.i_mode);
                  w_desc_nxt.src_pool = bus.i_src_pool;
                  w_desc_nxt.dst_pool = bus.i_dst_pool;
                  w_desc_nxt.src_half = bus.i_src_half;
                  w_desc_nxt.dst_half = bus.i_dst_half;
                  w_f_last_nxt = (w_desc_nxt.mode == M_POOL || bus.i_n_filters == '0) ?
                                 '0 : bus.i_n_filters - 1'b1;
                  w_l_last_nxt = (bus.i_n_loops == '0) ? '0 : bus.i_n_loops - 1'b1;
                  w_filter_nxt = '0;
                  w_loop_nxt   = '0;
                  w_state_nxt  = (w_desc_nxt.mode == M_RSVD) ? DONE : RUN;
                  w_desc_err   = (w_desc_nxt.mode == M_RSVD) ||
                                 ((w_desc_nxt.mode == M_CONV || w_desc_nxt.mode == M_POOL) &&
                                  bus.i_src_pool == bus.i_dst_pool &&
                                  bus.i_src_half == bus.i_dst_half);
               end
            end
            RUN: begin
               if (bus.i_step) begin
                  if (r_filter == r_f_last) begin
                     if (r_loop == r_l_last) begin
                        w_state_nxt = DONE;
                     end else begin
                        w_filter_nxt = '0;
                        w_loop_nxt   = r_loop + 1'b1;
                     end
                  end else begin
                     w_filter_nxt = r_filter + 1'b1;
                  end
               end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   assign w_active = (w_state_nxt == RUN);

   bank_group_decoder #(
      .NBANK(N_BIG), .SA_UNITS(SA_UNITS), .POOL_UNITS(POOL_UNITS), .CNT_W(CNT_W)
   ) u_big_dec (
      .i_active (w_active),
      .i_mode   (w_desc_nxt.mode),
      .i_rd_sel (w_desc_nxt.src_pool == POOL_BIG),
      .i_wr_sel (w_desc_nxt.dst_pool == POOL_BIG),
      .i_rd_half(w_desc_nxt.src_half),
      .i_wr_half(w_desc_nxt.dst_half),
      .i_filter (w_filter_nxt),
      .i_loop   (w_loop_nxt),
      .o_ena    (w_big_ena_raw),
      .o_enb    (w_big_enb),
      .o_wr_oob (w_big_oob)
   );

   bank_group_decoder #(
      .NBANK(N_SMALL), .SA_UNITS(SA_UNITS), .POOL_UNITS(POOL_UNITS), .CNT_W(CNT_W)
   ) u_small_dec (
      .i_active (w_active),
      .i_mode   (w_desc_nxt.mode),
      .i_rd_sel (w_desc_nxt.src_pool == POOL_SMALL),
      .i_wr_sel (w_desc_nxt.dst_pool == POOL_SMALL),
      .i_rd_half(w_desc_nxt.src_half),
      .i_wr_half(w_desc_nxt.dst_half),
      .i_filter (w_filter_nxt),
      .i_loop   (w_loop_nxt),
      .o_ena    (w_small_ena_raw),
      .o_enb    (w_small_enb),
      .o_wr_oob (w_small_oob)
   );

`ifdef BANK_CONFLICT_CHK_EN
   assign w_big_clash   = w_big_ena_raw & w_big_enb;
   assign w_small_clash = w_small_ena_raw & w_small_enb;
`else
   assign w_big_clash   = '0;
   assign w_small_clash = '0;
`endif

   always_comb begin
      w_cfg_err_nxt = w_start_acc ? w_desc_err : r_cfg_err;
      w_cfg_err_nxt = w_cfg_err_nxt | w_big_oob | w_small_oob |
                      (|w_big_clash) | (|w_small_clash);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_desc      <= '0;
         r_f_last    <= '0;
         r_l_last    <= '0;
         r_filter    <= '0;
         r_loop      <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_cfg_err   <= 1'b0;
         r_big_ena   <= '0;
         r_big_enb   <= '0;
         r_small_ena <= '0;
         r_small_enb <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_desc      <= w_desc_nxt;
         r_f_last    <= w_f_last_nxt;
         r_l_last    <= w_l_last_nxt;
         r_filter    <= w_filter_nxt;
         r_loop      <= w_loop_nxt;
         r_busy      <= (w_state_nxt != IDLE);
         r_done      <= (w_state_nxt == DONE);
         r_cfg_err   <= w_cfg_err_nxt;
         r_big_ena   <= w_big_ena_raw & ~w_big_clash;
         r_big_enb   <= w_big_enb;
         r_small_ena <= w_small_ena_raw & ~w_small_clash;
         r_small_enb <= w_small_enb;
      end
   end

   assign bus.o_busy       = r_busy;
   assign bus.o_done       = r_done;
   assign bus.o_filter_idx = r_filter;
   assign bus.o_loop_idx   = r_loop;
   assign bus.o_big_ena    = r_big_ena;
   assign bus.o_big_enb    = r_big_enb;
   assign bus.o_small_ena  = r_small_ena;
   assign bus.o_small_enb  = r_small_enb;
   assign bus.o_cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_bram_bank_enable_sequencer.sv
// Table-driven, scoreboard-checked bench for the BRAM bank enable sequencer (default build).
module tb_bram_bank_enable_sequencer;
   import bram_seq_pkg::*;

   localparam int unsigned NB = 12;
   localparam int unsigned NS = 32;
   localparam int unsigned CW = 5;

   localparam logic [2:0] C_NONE  = 3'b000;
   localparam logic [2:0] C_STEP  = 3'b001;
   localparam logic [2:0] C_ABORT = 3'b010;
   localparam logic [2:0] C_AS    = 3'b011;
   localparam logic [2:0] C_START = 3'b100;
   localparam logic [2:0] C_SA    = 3'b110;

   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_BUSY = 2'b10;
   localparam logic [1:0] S_DONE = 2'b11;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bram_bank_enable_sequencer_if #(.N_BIG(NB), .N_SMALL(NS), .CNT_W(CW)) bus ();

   bram_bank_enable_sequencer #(
      .N_BIG(NB), .N_SMALL(NS), .SA_UNITS(4), .POOL_UNITS(4), .CNT_W(CW)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   typedef struct {
      logic [2:0]  ctl;
      logic [1:0]  bd;
      logic [4:0]  fi;
      logic [4:0]  li;
      logic [11:0] bena;
      logic [11:0] benb;
      logic [31:0] sena;
      logic [31:0] senb;
      logic        err;
   } row_t;

   row_t tbl[$];
   row_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   rowno    = 0;

   function automatic row_t R(input logic [2:0] ctl, input logic [1:0] bd,
                              input logic [4:0] fi, input logic [4:0] li,
                              input logic [11:0] bena, input logic [11:0] benb,
                              input logic [31:0] sena, input logic [31:0] senb,
                              input logic err);
      row_t r;
      r.ctl = ctl; r.bd = bd; r.fi = fi; r.li = li;
      r.bena = bena; r.benb = benb; r.sena = sena; r.senb = senb; r.err = err;
      return r;
   endfunction

   task automatic chk(input string tag, input string fld, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s row%0d %s got=%0h exp=%0h", tag, rowno, fld, act, exp);
      end
   endtask

   task automatic set_desc(input logic [1:0] mode, input logic sp, input logic dp,
                           input logic sh, input logic dh, input logic [4:0] nf,
                           input logic [4:0] nl);
      bus.i_mode = mode;       bus.i_src_pool = sp; bus.i_dst_pool = dp;
      bus.i_src_half = sh;     bus.i_dst_half = dh;
      bus.i_n_filters = nf;    bus.i_n_loops = nl;
   endtask

   task automatic pop_and_check(input string tag);
      row_t e;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s row%0d scoreboard got=empty exp=entry", tag, rowno);
         return;
      end
      e = exp_q.pop_front();
      chk(tag, "busy",      32'(bus.o_busy),       32'(e.bd[1]));
      chk(tag, "done",      32'(bus.o_done),       32'(e.bd[0]));
      chk(tag, "filter",    32'(bus.o_filter_idx), 32'(e.fi));
      chk(tag, "loop",      32'(bus.o_loop_idx),   32'(e.li));
      chk(tag, "big_ena",   32'(bus.o_big_ena),    32'(e.bena));
      chk(tag, "big_enb",   32'(bus.o_big_enb),    32'(e.benb));
      chk(tag, "small_ena", bus.o_small_ena,       e.sena);
      chk(tag, "small_enb", bus.o_small_enb,       e.senb);
      chk(tag, "cfg_err",   32'(bus.o_cfg_err),    32'(e.err));
   endtask

   // One clock: drive controls, queue the expectation, sample 1 ns after the edge.
   task automatic cyc(input row_t r, input string tag);
      bus.i_start = r.ctl[2];
      bus.i_abort = r.ctl[1];
      bus.i_step  = r.ctl[0];
      exp_q.push_back(r);
      @(posedge clk);
      #1;
      rowno++;
      pop_and_check(tag);
   endtask

   task automatic run_tbl(input string tag);
      for (int i = 0; i < tbl.size(); i++) cyc(tbl[i], tag);
      tbl.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.i_start = 1'b0; bus.i_abort = 1'b0; bus.i_step = 1'b0;
      set_desc(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 5'd2);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // reset state, then start+abort together in IDLE (abort wins)
      tbl.push_back(R(C_NONE, S_IDLE, 0, 0, 12'h000, 12'h000, 0, 0, 0));
      tbl.push_back(R(C_SA,   S_IDLE, 0, 0, 12'h000, 12'h000, 0, 0, 0));
      run_tbl("reset");

      // CONV BIG->BIG, read half0, write half1, 3 filters x 2 loops
      set_desc(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 5'd2);
      tbl.push_back(R(C_START, S_BUSY, 0, 0, 12'h040, 12'h00F, 0, 0, 0));
      tbl.push_back(R(C_STEP,  S_BUSY, 1, 0, 12'h080, 12'h00F, 0, 0, 0));
      tbl.push_back(R(C_NONE,  S_BUSY, 1, 0, 12'h080, 12'h00F, 0, 0, 0));
      tbl.push_back(R(C_STEP,  S_BUSY, 2, 0, 12'h100, 12'h00F, 0, 0, 0));
      tbl.push_back(R(C_STEP,  S_BUSY, 0, 1, 12'h040, 12'h03C, 0, 0, 0));
      tbl.push_back(R(C_START, S_BUSY, 0, 1, 12'h040, 12'h03C, 0, 0, 0));
      tbl.push_back(R(C_STEP,  S_BUSY, 1, 1, 12'h080, 12'h03C, 0, 0, 0));
      tbl.push_back(R(C_STEP,  S_BUSY, 2, 1, 12'h100, 12'h03C, 0, 0, 0));
      tbl.push_back(R(C_STEP,  S_DONE, 2, 1, 12'h000, 12'h000, 0, 0, 0));
      tbl.push_back(R(C_NONE,  S_IDLE, 2, 1, 12'h000, 12'h000, 0, 0, 0));
      tbl.push_back(R(C_STEP,  S_IDLE, 2, 1, 12'h000, 12'h000, 0, 0, 0));
      run_tbl("conv");

      // POOL SMALL, read half1, write half0, 4 loops; n_filters ignored
      set_desc(2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd7, 5'd4);
      tbl.push_back(R(C_START, S_BUSY, 0, 0, 0, 0, 32'h0000_000F, 32'h000F_0000, 0));
      tbl.push_back(R(C_STEP,  S_BUSY, 0, 1, 0, 0, 32'h0000_00F0, 32'h00F0_0000, 0));
      tbl.push_back(R(C_STEP,  S_BUSY, 0, 2, 0, 0, 32'h0000_0F00, 32'h0F00_0000, 0));
      tbl.push_back(R(C_STEP,  S_BUSY, 0, 3, 0, 0, 32'h0000_F000, 32'hF000_0000, 0));
      tbl.push_back(R(C_STEP,  S_DONE, 0, 3, 0, 0, 32'h0000_0000, 32'h0000_0000, 0));
      tbl.push_back(R(C_NONE,  S_IDLE, 0, 3, 0, 0, 32'h0000_0000, 32'h0000_0000, 0));
      run_tbl("pool");

      // FC SMALL read half1, held until step
      set_desc(2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 5'd1);
      tbl.push_back(R(C_START, S_BUSY, 0, 0, 0, 0, 0, 32'hFFFF_0000, 0));
      tbl.push_back(R(C_NONE,  S_BUSY, 0, 0, 0, 0, 0, 32'hFFFF_0000, 0));
      tbl.push_back(R(C_NONE,  S_BUSY, 0, 0, 0, 0, 0, 32'hFFFF_0000, 0));
      tbl.push_back(R(C_STEP,  S_DONE, 0, 0, 0, 0, 0, 32'h0000_0000, 0));
      tbl.push_back(R(C_NONE,  S_IDLE, 0, 0, 0, 0, 0, 32'h0000_0000, 0));
      run_tbl("fc");

      // abort on the third cycle of a CONV layer, then a clean restart
      set_desc(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 5'd2);
      cyc(R(C_START, S_BUSY, 0, 0, 12'h040, 12'h00F, 0, 0, 0), "abort");
      cyc(R(C_STEP,  S_BUSY, 1, 0, 12'h080, 12'h00F, 0, 0, 0), "abort");
      cyc(R(C_AS,    S_IDLE, 0, 0, 12'h000, 12'h000, 0, 0, 0), "abort");
      cyc(R(C_NONE,  S_IDLE, 0, 0, 12'h000, 12'h000, 0, 0, 0), "abort");
      cyc(R(C_START, S_BUSY, 0, 0, 12'h040, 12'h00F, 0, 0, 0), "abort");
      cyc(R(C_STEP,  S_BUSY, 1, 0, 12'h080, 12'h00F, 0, 0, 0), "abort");
      cyc(R(C_ABORT, S_IDLE, 0, 0, 12'h000, 12'h000, 0, 0, 0), "abort");

      // CONV with more filters than banks in the write half (H=6)
      set_desc(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 5'd1);
      cyc(R(C_START, S_BUSY, 0, 0, 12'h040, 12'h00F, 0, 0, 0), "oob");
      cyc(R(C_STEP,  S_BUSY, 1, 0, 12'h080, 12'h00F, 0, 0, 0), "oob");
      cyc(R(C_STEP,  S_BUSY, 2, 0, 12'h100, 12'h00F, 0, 0, 0), "oob");
      cyc(R(C_STEP,  S_BUSY, 3, 0, 12'h200, 12'h00F, 0, 0, 0), "oob");
      cyc(R(C_STEP,  S_BUSY, 4, 0, 12'h400, 12'h00F, 0, 0, 0), "oob");
      cyc(R(C_STEP,  S_BUSY, 5, 0, 12'h800, 12'h00F, 0, 0, 0), "oob");
      cyc(R(C_STEP,  S_BUSY, 6, 0, 12'h000, 12'h00F, 0, 0, 1), "oob");
      cyc(R(C_STEP,  S_BUSY, 7, 0, 12'h000, 12'h00F, 0, 0, 1), "oob");
      cyc(R(C_STEP,  S_DONE, 7, 0, 12'h000, 12'h000, 0, 0, 1), "oob");
      cyc(R(C_NONE,  S_IDLE, 7, 0, 12'h000, 12'h000, 0, 0, 1), "oob");

      // new start clears cfg_err; n_loops=0 runs a single loop
      set_desc(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 5'd0);
      cyc(R(C_START, S_BUSY, 0, 0, 12'h040, 12'h00F, 0, 0, 0), "nl0");
      cyc(R(C_STEP,  S_BUSY, 1, 0, 12'h080, 12'h00F, 0, 0, 0), "nl0");
      cyc(R(C_STEP,  S_BUSY, 2, 0, 12'h100, 12'h00F, 0, 0, 0), "nl0");
      cyc(R(C_STEP,  S_DONE, 2, 0, 12'h000, 12'h000, 0, 0, 0), "nl0");
      cyc(R(C_NONE,  S_IDLE, 2, 0, 12'h000, 12'h000, 0, 0, 0), "nl0");

      // reserved mode: straight to DONE with cfg_err; a rejected start keeps it
      set_desc(2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 5'd2);
      cyc(R(C_START, S_DONE, 0, 0, 12'h000, 12'h000, 0, 0, 1), "rsvd");
      cyc(R(C_NONE,  S_IDLE, 0, 0, 12'h000, 12'h000, 0, 0, 1), "rsvd");
      cyc(R(C_SA,    S_IDLE, 0, 0, 12'h000, 12'h000, 0, 0, 1), "rsvd");

      // same pool, same half: error on start, enables still driven
      set_desc(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 5'd2);
      cyc(R(C_START, S_BUSY, 0, 0, 12'h001, 12'h00F, 0, 0, 1), "samehalf");
      cyc(R(C_ABORT, S_IDLE, 0, 0, 12'h000, 12'h000, 0, 0, 1), "samehalf");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
